// File: rtl/overlap_frame_buffer.sv
// overlap_frame_buffer: ring-buffered framer emitting FRAME_SIZE-sample frames every HOP_SIZE new samples
module overlap_frame_buffer #(
    parameter int WIDTH      = 16,
    parameter int FRAME_SIZE = 306,
    parameter int HOP_SIZE   = 123,
    parameter int IDX_W      = $clog2(FRAME_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_first,
    output logic             out_last,
    output logic [15:0]      frame_count
);
    localparam int CW = IDX_W + 1;
    localparam logic [CW-1:0] FS_C = CW'(FRAME_SIZE);
    localparam logic [CW-1:0] HOP_C = CW'(HOP_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SIZE - 1);

    if (FRAME_SIZE < 2 || HOP_SIZE < 1 || HOP_SIZE > FRAME_SIZE) begin : g_bad_params
        $error("overlap_frame_buffer: need FRAME_SIZE >= 2 and 1 <= HOP_SIZE <= FRAME_SIZE");
    end

    typedef enum logic [1:0] {FILL_INIT, FILL_HOP, PAD, EMIT} state_t;
    state_t state, state_d;

    logic [WIDTH-1:0] ring [FRAME_SIZE];
    logic [IDX_W-1:0] wr_ptr, base, wr_ptr_inc, base_hop, rd_idx;
    logic [CW-1:0] cnt, cnt_inc, need, base_sum, rd_sum;
    logic eos, xfer, pad_wr, wr_en, done, out_hs, frame_end;

    always_comb begin
        in_ready   = (state == FILL_INIT || state == FILL_HOP) && !rst;
        out_valid  = state == EMIT && !rst;
        xfer       = in_valid && in_ready;
        pad_wr     = state == PAD && !rst;
        wr_en      = xfer || pad_wr;
        cnt_inc    = cnt + CW'(1);
        done       = wr_en && cnt_inc == need;
        out_hs     = out_valid && out_ready;
        frame_end  = out_hs && out_index == LAST_IDX;
        wr_ptr_inc = wr_ptr == LAST_IDX ? '0 : wr_ptr + IDX_W'(1);
        // both sums stay below 2*FRAME_SIZE, so one conditional subtract wraps them
        base_sum   = {1'b0, base} + HOP_C;
        base_hop   = IDX_W'(base_sum >= FS_C ? base_sum - FS_C : base_sum);
        rd_sum     = {1'b0, base} + {1'b0, out_index};
        rd_idx     = IDX_W'(rd_sum >= FS_C ? rd_sum - FS_C : rd_sum);
        out_data   = ring[rd_idx];
        out_first  = out_index == '0;
        out_last   = out_index == LAST_IDX;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            FILL_INIT, FILL_HOP: if (xfer) state_d = done ? EMIT : (in_last ? PAD : state);
            PAD:                 if (done) state_d = EMIT;
            EMIT:                if (frame_end) state_d = eos ? FILL_INIT : FILL_HOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL_INIT;
            wr_ptr      <= '0;
            base        <= '0;
            cnt         <= '0;
            need        <= FS_C;
            out_index   <= '0;
            eos         <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_d;
            if (wr_en) begin
                wr_ptr <= wr_ptr_inc;
                cnt    <= done ? '0 : cnt_inc;
            end
            if (done && (pad_wr || in_last))
                eos <= 1'b1;
            if (out_hs)
                out_index <= frame_end ? '0 : out_index + IDX_W'(1);
            // a frame ending the stream restarts a full fill from a clean ring origin
            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
                if (eos) begin
                    base   <= '0;
                    wr_ptr <= '0;
                    cnt    <= '0;
                    eos    <= 1'b0;
                    need   <= FS_C;
                end else begin
                    base <= base_hop;
                    need <= HOP_C;
                end
            end
        end
    end

    always_ff @(posedge clk)
        if (wr_en) ring[wr_ptr] <= pad_wr ? '0 : in_data;
endmodule

// File: tb/tb_overlap_frame_buffer.sv
// tb_overlap_frame_buffer: scoreboard bench for an 8/3 overlapping framer and an 8/8 non-overlapping one
module tb_overlap_frame_buffer;
    logic clk = 1'b0, rst = 1'b1, ordy = 1'b1, tog = 1'b0, bp = 1'b0;
    logic iv0 = 1'b0, il0 = 1'b0, iv1 = 1'b0, il1 = 1'b0;
    logic [15:0] id0 = '0, id1 = '0;
    logic rdy0, ov0, of0, ol0, rdy1, ov1, of1, ol1;
    logic [15:0] od0, od1, fc0, fc1;
    logic [2:0] oi0, oi1;
    int checks = 0, errors = 0, pops0 = 0;

    typedef struct {logic [15:0] d; logic [2:0] i;} exp_t;
    exp_t q0[$], q1[$];

    overlap_frame_buffer #(.WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(3)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in_data(id0), .in_last(il0),
        .out_valid(ov0), .out_ready(ordy), .out_data(od0), .out_index(oi0),
        .out_first(of0), .out_last(ol0), .frame_count(fc0));

    overlap_frame_buffer #(.WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_data(id1), .in_last(il1),
        .out_valid(ov1), .out_ready(ordy), .out_data(od1), .out_index(oi1),
        .out_first(of1), .out_last(ol1), .frame_count(fc1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tog  = !tog;
        ordy = bp ? tog : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // every presented output is compared against the queue head; stalled cycles re-check it
    always @(negedge clk) if (ov0) begin
        if (q0.size() == 0) chk("d0_unexpected_valid", 1, 0);
        else begin
            chk("d0_data", od0, q0[0].d);
            chk("d0_index", oi0, q0[0].i);
            chk("d0_first", of0, q0[0].i == 3'd0);
            chk("d0_last", ol0, q0[0].i == 3'd7);
            chk("d0_in_ready_in_emit", rdy0, 0);
            if (ordy) begin
                void'(q0.pop_front());
                pops0++;
            end
        end
    end

    always @(negedge clk) if (ov1) begin
        if (q1.size() == 0) chk("d1_unexpected_valid", 1, 0);
        else begin
            chk("d1_data", od1, q1[0].d);
            chk("d1_index", oi1, q1[0].i);
            chk("d1_first", of1, q1[0].i == 3'd0);
            chk("d1_last", ol1, q1[0].i == 3'd7);
            if (ordy) void'(q1.pop_front());
        end
    end

    task automatic push_seq(input bit sel, input int start, input int n);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d = i < n ? 16'(start + i) : 16'd0;
            e.i = 3'(i);
            if (sel) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic send(input bit sel, input logic [15:0] d, input logic l);
        int k = 0;
        if (sel) begin iv1 = 1'b1; id1 = d; il1 = l; end
        else begin iv0 = 1'b1; id0 = d; il0 = l; end
        while (!(sel ? rdy1 : rdy0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k == 1000) timeout("send");
        @(negedge clk);
        iv0 = 1'b0; il0 = 1'b0; iv1 = 1'b0; il1 = 1'b0;
    endtask

    task automatic send_seq(input bit sel, input int start, input int n, input bit last);
        for (int i = 0; i < n; i++) send(sel, 16'(start + i), last && i == n - 1);
    endtask

    task automatic drain(input bit sel);
        int k = 0;
        while ((sel ? q1.size() : q0.size()) > 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k == 1000) timeout("drain");
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out_valid", ov0, 0);
        chk("reset_in_ready", rdy0, 0);
        chk("reset_frame_count", fc0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", rdy0, 1);

        push_seq(0, 1, 8);
        push_seq(0, 4, 8);
        send_seq(0, 1, 11, 0);
        drain(0);
        chk("overlap_frame_count", fc0, 2);

        reset_dut();
        chk("reset_again_frame_count", fc0, 0);
        bp = 1'b1;
        pops0 = 0;
        push_seq(0, 1, 8);
        send_seq(0, 1, 8, 0);
        drain(0);
        bp = 1'b0;
        chk("bp_handshakes", pops0, 8);
        chk("bp_frame_count", fc0, 1);

        reset_dut();
        push_seq(0, 1, 8);
        push_seq(0, 4, 7);
        send_seq(0, 1, 10, 1);
        drain(0);
        chk("eos_frame_count", fc0, 2);
        chk("eos_back_to_fill_init", rdy0, 1);
        push_seq(0, 21, 8);
        send_seq(0, 21, 8, 0);
        drain(0);
        chk("fresh_frame_count", fc0, 3);

        reset_dut();
        push_seq(0, 1, 5);
        send_seq(0, 1, 5, 1);
        drain(0);
        chk("short_frame_count", fc0, 1);

        reset_dut();
        push_seq(0, 1, 8);
        send_seq(0, 1, 8, 0);
        begin
            int k = 0;
            while (!(ov0 && oi0 == 3'd4) && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k == 100) timeout("mid_emit_index4");
        end
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_emit_reset_out_valid", ov0, 0);
        chk("mid_emit_reset_frame_count", fc0, 0);
        q0.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_emit_reset_in_ready", rdy0, 1);

        push_seq(1, 1, 8);
        push_seq(1, 9, 8);
        send_seq(1, 1, 16, 0);
        drain(1);
        chk("nonoverlap_frame_count", fc1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/overlap_frame_buffer.md
OVERLAP_FRAME_BUFFER -- requirements
Module: overlap_frame_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter FRAME_SIZE, default 306, meaning samples per frame and ring depth; legal values are 2 or more.
REQ-003 The block SHALL have parameter HOP_SIZE, default 123, meaning new samples between frames; legal range is 1 to FRAME_SIZE, with elaboration failing outside it.
REQ-004 The block SHALL have derived parameter IDX_W = $clog2(FRAME_SIZE), meaning index and pointer width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the input sample is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the input sample.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: input sample.
REQ-010 The block SHALL have port in_last, input, 1 bit: the accepted sample is the last of the stream.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: frame sample.
REQ-014 The block SHALL have port out_index, output, IDX_W bits: position of out_data in the frame, 0 to FRAME_SIZE-1.
REQ-015 The block SHALL have port out_first, output, 1 bit: high with index 0.
REQ-016 The block SHALL have port out_last, output, 1 bit: high with index FRAME_SIZE-1.
REQ-017 The block SHALL have port frame_count, output, 16 bits: count of fully emitted frames; wraps modulo 2^16.

Function
REQ-018 Storage SHALL be a FRAME_SIZE-entry ring with write pointer wr_ptr and frame base pointer base, both IDX_W bits; all pointer increments wrap modulo FRAME_SIZE.
REQ-019 The FSM states SHALL be FILL_INIT, FILL_HOP, PAD and EMIT.
REQ-020 In FILL_INIT, need is FRAME_SIZE; in FILL_HOP, need is HOP_SIZE; a counter cnt SHALL count accepted or padded samples toward need.
REQ-021 An input transfer SHALL occur when in_valid && in_ready; it writes in_data at wr_ptr, advances wr_ptr, and increments cnt.
REQ-022 in_ready SHALL be 1 only in FILL_INIT and FILL_HOP, and SHALL be combinational from state only, with no dependence on in_valid.
REQ-023 When a transfer makes cnt reach need, the next state SHALL be EMIT, with cnt cleared.
REQ-024 When a transfer has in_last=1 and cnt+1 < need, the next state SHALL be PAD.
REQ-025 When a transfer has in_last=1 and cnt+1 = need, the next state SHALL be EMIT, with end-of-stream flag eos set.
REQ-026 PAD SHALL write one zero per cycle at wr_ptr, advancing wr_ptr and cnt, until cnt reaches need, then go to EMIT with eos set.
REQ-027 In EMIT, out_valid SHALL be 1 and out_data SHALL equal ring[(base+out_index) mod FRAME_SIZE].
REQ-028 The first out_valid of a frame SHALL occur the cycle after the completing transfer or final pad write.
REQ-029 out_index SHALL advance only on out_valid && out_ready.
REQ-030 While out_valid && !out_ready, out_data, out_index, out_first and out_last SHALL hold stable.
REQ-031 On the handshake with out_last=1, frame_count SHALL increment and out_index SHALL clear.
REQ-032 On that handshake, if eos=0, base SHALL become (base+HOP_SIZE) mod FRAME_SIZE and the next state SHALL be FILL_HOP.
REQ-033 On that handshake, if eos=1, base, wr_ptr, cnt and eos SHALL clear and the next state SHALL be FILL_INIT; frame_count is preserved.
REQ-034 When HOP_SIZE = FRAME_SIZE, frames SHALL be non-overlapping and base SHALL remain 0.
REQ-035 The ring SHALL never be written during EMIT; input is stalled via in_ready=0.
REQ-036 in_last with in_valid=0 SHALL be ignored.

Reset
REQ-037 While rst=1 at a clock edge, the FSM SHALL go to FILL_INIT; wr_ptr, base, cnt, out_index, eos and frame_count SHALL go to 0.
REQ-038 During reset, out_valid=0 and in_ready=0; in_ready=1 the first cycle after rst deasserts.
REQ-039 Reset SHALL be honoured in any state, including mid-EMIT and mid-PAD, and SHALL abandon any partial frame.
REQ-040 Ring contents SHALL NOT be reset.

Verification
Configuration for REQ-041 to REQ-045: WIDTH=16, FRAME_SIZE=8, HOP_SIZE=3.
REQ-041 Reset: hold rst 3 cycles -> out_valid=0, in_ready=0, frame_count=0; in_ready=1 the next cycle.
REQ-042 Basic overlap: stream 1..11, out_ready=1 -> frame 1..8 with first on 1 and last on 8, then frame 4..11; frame_count=2.
REQ-043 Backpressure: stream 1..8, out_ready alternating 0/1 -> each sample held stable while stalled; 8 handshakes; in_ready=0 throughout EMIT.
REQ-044 EOS pad: stream 1..10 with in_last on 10 -> frame 4,5,6,7,8,9,10,0; then FILL_INIT, and the next 8 samples form a fresh frame.
REQ-045 Short stream and mid-emit reset: stream 1..5 with in_last on 5 -> frame 1,2,3,4,5,0,0,0; separately, assert rst at index 4 of a frame -> out_valid=0 the next cycle, frame_count=0.
REQ-046 The bench SHALL check HOP_SIZE=FRAME_SIZE=8 with stream 1..16 -> frames 1..8 and 9..16 with no overlap.
